guess_buffer: RTL and testbench

Input-side guess buffer for the wireless hangman receiver. Each time the UART receiver flags a completed byte, the block accepts the byte and queues it in a small FIFO. With filtering enabled, only letters are accepted and they are folded to uppercase. When the game FSM signals it is ready for a guess, the oldest queued byte is released as a one-cycle-valid guess. It sits between the UART Rx and the hangman game controller.

---
 rtl/hangman_pkg.sv | 20 ++
 rtl/guess_buffer_if.sv | 24 ++
 rtl/guess_fifo.sv | 56 +++++
 rtl/guess_buffer.sv | 80 ++++++++
 tb/tb_guess_buffer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/hangman_pkg.sv
// Shared types and ASCII constants for the wireless hangman receiver.
package hangman_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t ASCII_A_UP  = 8'h41;
    localparam byte_t ASCII_Z_UP  = 8'h5A;
    localparam byte_t ASCII_A_LO  = 8'h61;
    localparam byte_t ASCII_Z_LO  = 8'h7A;
    localparam byte_t CASE_OFFSET = 8'h20;

    function automatic logic is_upper(input byte_t b);
        return (b >= ASCII_A_UP) && (b <= ASCII_Z_UP);
    endfunction

    function automatic logic is_lower(input byte_t b);
        return (b >= ASCII_A_LO) && (b <= ASCII_Z_LO);
    endfunction

endpackage

// File: rtl/guess_buffer_if.sv
// Byte-in / guess-out signal bundle between UART Rx, guess_buffer and game controller.
interface guess_buffer_if;
    import hangman_pkg::*;

    logic  ready;
    byte_t Rx_byte;
    logic  game_rdy;
    byte_t guess;
    logic  guess_valid;
    logic  empty;
    logic  full;
    logic  dropped;

    modport master (
        output ready, Rx_byte, game_rdy,
        input  guess, guess_valid, empty, full, dropped
    );

    modport slave (
        input  ready, Rx_byte, game_rdy,
        output guess, guess_valid, empty, full, dropped
    );

endinterface

// File: rtl/guess_fifo.sv
// Parameterised synchronous byte FIFO; a write is allowed when full if a read happens in the same cycle.
module guess_fifo
    import hangman_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  byte_t wr_data,
    input  logic  rd_en,
    output byte_t rd_data,
    output logic  empty,
    output logic  full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    byte_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; contents are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/guess_buffer.sv
// Queues UART bytes and releases them one per game_rdy rising edge.
// Define GUESS_BUFFER_FILTER_EN to accept letters only, folded to uppercase.
module guess_buffer
    import hangman_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    guess_buffer_if.slave  bus
);

    logic  ready_q;
    logic  game_rdy_q;
    logic  push_req;
    logic  pop_req;
    logic  accept;
    byte_t store_byte;
    logic  fifo_empty;
    logic  fifo_full;
    byte_t fifo_rd_data;
    logic  do_push;
    logic  do_pop;

    assign push_req = bus.ready & ~ready_q;
    assign pop_req  = bus.game_rdy & ~game_rdy_q;

`ifdef GUESS_BUFFER_FILTER_EN
    always_comb begin
        accept     = 1'b0;
        store_byte = bus.Rx_byte;
        if (is_upper(bus.Rx_byte)) begin
            accept = 1'b1;
        end else if (is_lower(bus.Rx_byte)) begin
            accept     = 1'b1;
            store_byte = bus.Rx_byte - CASE_OFFSET;
        end
    end
`else
    assign accept     = 1'b1;
    assign store_byte = bus.Rx_byte;
`endif

    // Pop is decided on pre-write occupancy, so an empty FIFO never bypasses.
    assign do_pop  = pop_req & ~fifo_empty;
    assign do_push = push_req & accept & (~fifo_full | do_pop);

    guess_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (do_push),
        .wr_data (store_byte),
        .rd_en   (do_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign bus.empty = fifo_empty;
    assign bus.full  = fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q         <= 1'b0;
            game_rdy_q      <= 1'b0;
            bus.guess       <= '0;
            bus.guess_valid <= 1'b0;
            bus.dropped     <= 1'b0;
        end else begin
            ready_q         <= bus.ready;
            game_rdy_q      <= bus.game_rdy;
            bus.guess_valid <= do_pop;
            bus.dropped     <= push_req & ~do_push;
            if (do_pop) begin
                bus.guess <= fifo_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_guess_buffer.sv
// Directed self-checking bench for guess_buffer (DEPTH=4); follows GUESS_BUFFER_FILTER_EN if defined.
module tb_guess_buffer;
    import hangman_pkg::*;

    logic tb_clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    guess_buffer_if bus ();

    guess_buffer #(.DEPTH(4)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic push(input byte_t b);
        bus.ready   = 1'b1;
        bus.Rx_byte = b;
        step();
        bus.ready = 1'b0;
        step();
    endtask

    task automatic pop_expect(input string tag, input byte_t b);
        bus.game_rdy = 1'b1;
        step();
        check({tag, "_valid"}, 32'(bus.guess_valid), 32'd1);
        check({tag, "_guess"}, 32'(bus.guess), 32'(b));
        bus.game_rdy = 1'b0;
        step();
        check({tag, "_valid_low"}, 32'(bus.guess_valid), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.ready    = 1'b0;
        bus.Rx_byte  = 8'h00;
        bus.game_rdy = 1'b0;
        step();
        step();
        check("rst_guess", 32'(bus.guess), 32'h00);
        check("rst_valid", 32'(bus.guess_valid), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_dropped", 32'(bus.dropped), 32'd0);
        rst = 1'b0;
        step();

        // Non-letter held for two cycles
        bus.ready   = 1'b1;
        bus.Rx_byte = 8'h05;
        step();
`ifdef GUESS_BUFFER_FILTER_EN
        check("nl_empty", 32'(bus.empty), 32'd1);
        check("nl_dropped", 32'(bus.dropped), 32'd1);
`else
        check("nl_empty", 32'(bus.empty), 32'd0);
        check("nl_dropped", 32'(bus.dropped), 32'd0);
`endif
        step();
        check("nl_dropped_once", 32'(bus.dropped), 32'd0);
        bus.ready = 1'b0;
        step();
`ifndef GUESS_BUFFER_FILTER_EN
        pop_expect("nl_pop", 8'h05);
`endif
        check("nl_empty_after", 32'(bus.empty), 32'd1);

        // Lowercase, then game_rdy held two cycles
        push(8'h61);
        check("cf_empty", 32'(bus.empty), 32'd0);
        bus.game_rdy = 1'b1;
        step();
        check("cf_valid", 32'(bus.guess_valid), 32'd1);
`ifdef GUESS_BUFFER_FILTER_EN
        check("cf_guess", 32'(bus.guess), 32'h41);
`else
        check("cf_guess", 32'(bus.guess), 32'h61);
`endif
        step();
        check("cf_no_second_pop", 32'(bus.guess_valid), 32'd0);
        check("cf_empty_after", 32'(bus.empty), 32'd1);
        bus.game_rdy = 1'b0;
        step();

        // Pop while empty
        bus.game_rdy = 1'b1;
        step();
        check("ep_valid", 32'(bus.guess_valid), 32'd0);
`ifdef GUESS_BUFFER_FILTER_EN
        check("ep_guess", 32'(bus.guess), 32'h41);
`else
        check("ep_guess", 32'(bus.guess), 32'h61);
`endif
        bus.game_rdy = 1'b0;
        step();

        // Push and pop on same edge while empty: stored, not released
        bus.ready    = 1'b1;
        bus.Rx_byte  = 8'h47;
        bus.game_rdy = 1'b1;
        step();
        check("nb_valid", 32'(bus.guess_valid), 32'd0);
        check("nb_empty", 32'(bus.empty), 32'd0);
        bus.ready    = 1'b0;
        bus.game_rdy = 1'b0;
        step();
        pop_expect("nb_pop", 8'h47);

        // Minimum latency: push at N, pop at N+1
        bus.ready   = 1'b1;
        bus.Rx_byte = 8'h5A;
        step();
        bus.ready    = 1'b0;
        bus.game_rdy = 1'b1;
        step();
        check("ml_valid", 32'(bus.guess_valid), 32'd1);
        check("ml_guess", 32'(bus.guess), 32'h5A);
        bus.game_rdy = 1'b0;
        step();

        // Fill, overflow, simultaneous push/pop when full
        push(8'h41);
        push(8'h42);
        push(8'h43);
        check("of_not_full3", 32'(bus.full), 32'd0);
        push(8'h44);
        check("of_full", 32'(bus.full), 32'd1);
        bus.ready   = 1'b1;
        bus.Rx_byte = 8'h45;
        step();
        check("of_dropped", 32'(bus.dropped), 32'd1);
        bus.ready = 1'b0;
        step();
        check("of_dropped_low", 32'(bus.dropped), 32'd0);
        check("of_still_full", 32'(bus.full), 32'd1);

        bus.ready    = 1'b1;
        bus.Rx_byte  = 8'h45;
        bus.game_rdy = 1'b1;
        step();
        check("sim_valid", 32'(bus.guess_valid), 32'd1);
        check("sim_guess", 32'(bus.guess), 32'h41);
        check("sim_full", 32'(bus.full), 32'd1);
        check("sim_dropped", 32'(bus.dropped), 32'd0);
        bus.ready    = 1'b0;
        bus.game_rdy = 1'b0;
        step();

        pop_expect("pop_b", 8'h42);
        check("pop_not_full", 32'(bus.full), 32'd0);
        pop_expect("pop_c", 8'h43);
        pop_expect("pop_d", 8'h44);
        pop_expect("pop_e", 8'h45);
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Reset mid-operation discards contents
        push(8'h4B);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_empty", 32'(bus.empty), 32'd1);
        check("mr_guess", 32'(bus.guess), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
